// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer on refclk: holds PLL in reset, waits for synchronized lock, qualifies it
// over a stability window, then asserts ready. All outputs registered (1 cycle after decision), no backpressure.
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 17
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       relock_req,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       ready,
    output logic       timeout_pulse,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             ready_q, ready_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             timeout_evt;
    logic             loss_evt;

    // pll_locked is asynchronous to refclk; only locked_s_q is used for decisions.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            retry_q   <= 8'd0;
            loss_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        if (relock_req) begin
            // A relock request overrides everything, including a simultaneous loss of lock.
            state_d = ST_RESET;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a coincident timeout.
                    if (locked_s_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = ST_RESET;
                        cnt_d       = '0;
                        timeout_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s_q) begin
                        state_d  = ST_RESET;
                        cnt_d    = '0;
                        loss_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        pll_rst_d = (state_d == ST_RESET);
        ready_d   = (state_d == ST_RUN);
        timeout_d = timeout_evt;
        retry_d   = retry_q;
        loss_d    = loss_q;
        if (timeout_evt && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end
        if (loss_evt && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign ready         = ready_q;
    assign timeout_pulse = timeout_q;
    assign retry_cnt     = retry_q;
    assign loss_cnt      = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
// Tick index i means the i-th refclk rising edge after rst_n release (or after a scenario start).
module tb_pll_lock_ctrl;

    logic       refclk;
    logic       rst_n;
    logic       relock_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       ready;
    logic       timeout_pulse;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .CNT_W        (17)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .relock_req   (relock_req),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .ready        (ready),
        .timeout_pulse(timeout_pulse),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset(input logic lk, input string tag);
        rst_n      = 1'b0;
        relock_req = 1'b0;
        pll_locked = lk;
        tick();
        check({tag, "_rst_pll_rst"}, int'(pll_rst), 1);
        check({tag, "_rst_ready"}, int'(ready), 0);
        check({tag, "_rst_timeout"}, int'(timeout_pulse), 0);
        check({tag, "_rst_retry"}, int'(retry_cnt), 0);
        check({tag, "_rst_loss"}, int'(loss_cnt), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int fall, rise, nrst, nto;
        rst_n      = 1'b0;
        relock_req = 1'b0;
        pll_locked = 1'b0;
        #12;

        // Locked from the start: reset for 4 edges, WAIT_LOCK 1, STABLE 8.
        do_reset(1'b1, "t1");
        fall = -1; rise = -1; nto = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (fall < 0 && !pll_rst) fall = i;
            if (rise < 0 && ready) rise = i;
            if (timeout_pulse) nto++;
        end
        check("t1_pll_rst_fall", fall, 4);
        check("t1_ready_rise", rise, 13);
        check("t1_timeouts", nto, 0);
        check("t1_retry", int'(retry_cnt), 0);

        // Lock absent for 70 edges: timeouts at 24, 48, 72, then lock.
        do_reset(1'b0, "t2");
        rise = -1; nrst = 0; nto = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (pll_rst) nrst++;
            if (timeout_pulse) nto++;
            if (rise < 0 && ready) rise = i;
            if (i == 70) pll_locked = 1'b1;
        end
        check("t2_timeouts", nto, 3);
        check("t2_pll_rst_cycles", nrst, 15);
        check("t2_ready_rise", rise, 85);
        check("t2_retry", int'(retry_cnt), 3);

        // Lock arrives on the very cycle the timeout would fire: lock wins.
        do_reset(1'b0, "tw");
        rise = -1; nto = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout_pulse) nto++;
            if (rise < 0 && ready) rise = i;
            if (i == 21) pll_locked = 1'b1;
        end
        check("tw_timeouts", nto, 0);
        check("tw_ready_rise", rise, 32);
        check("tw_retry", int'(retry_cnt), 0);

        // One-cycle lock glitch seen in STABLE at count 5 restarts the window.
        do_reset(1'b1, "t3");
        rise = -1; nrst = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 8) pll_locked = 1'b0;
            if (i == 9) pll_locked = 1'b1;
            if (i >= 4 && pll_rst) nrst++;
            if (rise < 0 && ready) rise = i;
        end
        check("t3_ready_rise", rise, 20);
        check("t3_no_pll_rst", nrst, 0);
        check("t3_retry", int'(retry_cnt), 0);

        // Loss of lock in RUN.
        pll_locked = 1'b0;
        fall = -1; rise = -1; nrst = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (pll_rst) nrst++;
            if (fall >= 0 && rise < 0 && ready) rise = i;
            if (fall < 0 && !ready) begin
                fall = i;
                pll_locked = 1'b1;
            end
        end
        check("t4_ready_fall", fall, 3);
        check("t4_pll_rst_cycles", nrst, 4);
        check("t4_ready_rise", rise, 16);
        check("t4_loss", int'(loss_cnt), 1);
        check("t4_retry", int'(retry_cnt), 0);

        // One-cycle relock request in RUN.
        relock_req = 1'b1;
        fall = -1; rise = -1; nrst = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) relock_req = 1'b0;
            if (pll_rst) nrst++;
            if (fall < 0 && !ready) fall = i;
            if (fall >= 0 && rise < 0 && ready) rise = i;
        end
        check("t5_ready_fall", fall, 1);
        check("t5_pll_rst_cycles", nrst, 4);
        check("t5_ready_rise", rise, 14);
        check("t5_loss", int'(loss_cnt), 1);
        check("t5_retry", int'(retry_cnt), 0);

        // Relock request coinciding with synchronized loss of lock: no loss count.
        pll_locked = 1'b0;
        fall = -1; rise = -1;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 2) relock_req = 1'b1;
            if (i == 3) begin
                relock_req = 1'b0;
                pll_locked = 1'b1;
            end
            if (fall < 0 && !ready) fall = i;
            if (fall >= 0 && rise < 0 && ready) rise = i;
        end
        check("t5b_ready_fall", fall, 3);
        check("t5b_ready_rise", rise, 16);
        check("t5b_loss", int'(loss_cnt), 1);

        // 300 timeouts saturate retry_cnt; then async reset mid-WAIT_LOCK.
        do_reset(1'b0, "t6");
        nto = 0;
        for (int i = 1; i <= 7200; i++) begin
            tick();
            if (timeout_pulse) nto++;
            if (i == 6120) check("t6_retry_at_255", int'(retry_cnt), 255);
        end
        check("t6_timeouts", nto, 300);
        check("t6_retry_sat", int'(retry_cnt), 255);
        for (int i = 1; i <= 6; i++) tick();
        check("t6_wait_pll_rst", int'(pll_rst), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_pll_rst", int'(pll_rst), 1);
        check("t6_async_ready", int'(ready), 0);
        check("t6_async_retry", int'(retry_cnt), 0);
        check("t6_async_loss", int'(loss_cnt), 0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
Sequencing controller that sits directly upstream and downstream of the 27 MHz core PLL. It drives the PLL reset input and consumes its locked output. It qualifies lock with a stability window, retries the PLL on lock timeout, and issues a clean `ready` that gates release of the core-domain reset. It runs entirely on the 50 MHz board reference clock, which is also the PLL input.

Parameters:
- RST_CYCLES, 16: refclk cycles `pll_rst` is held high per reset attempt (≥ 1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed in WAIT_LOCK before retry (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before `ready`.
- CNT_W, 17: state-counter width; must satisfy 2^CNT_W > max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- refclk, in, 1: 50 MHz reference clock; the only clock.
- rst_n, in, 1: asynchronous active-low reset.
- relock_req, in, 1: synchronous request to restart the PLL sequence. Level-sensitive; acted on every cycle it is high.
- pll_locked, in, 1: PLL LOCKED output; asynchronous to refclk.
- pll_rst, out, 1: drives PLL RST, active-high.
- ready, out, 1: PLL output is stable; core reset may deassert.
- timeout_pulse, out, 1: one-cycle pulse on each lock timeout.
- retry_cnt, out, 8: lock timeouts since rst_n; saturates at 255.
- loss_cnt, out, 8: losses of lock while in RUN; saturates at 255.

Behaviour:
- All outputs are registered.
- Async reset (rst_n low) values:
  - state = RESET, counter = 0, `pll_rst` = 1, `ready` = 0, `timeout_pulse` = 0.
  - `retry_cnt` = 0, `loss_cnt` = 0, both synchronizer flops = 0.
- Lock synchronizer: `pll_locked` passes through 2 refclk flops to give `locked_s`. Latency is 2 cycles; all decisions use `locked_s`.
- Global rule: `relock_req` = 1 in any state forces next state RESET with counter = 0. It has priority over every transition below and does not change either counter.
- RESET:
  - `pll_rst` = 1, `ready` = 0.
  - The counter increments each cycle.
  - When counter = RST_CYCLES-1: go to WAIT_LOCK, counter = 0.
  - `pll_rst` is therefore high for exactly RST_CYCLES cycles after the entry cycle.
- WAIT_LOCK:
  - `pll_rst` = 0, `ready` = 0.
  - If `locked_s` = 1: go to STABLE, counter = 0.
  - Else if counter = LOCK_TIMEOUT-1: go to RESET, counter = 0, `timeout_pulse` = 1 for 1 cycle, `retry_cnt` += 1 (saturating).
  - Else the counter increments.
- STABLE:
  - `pll_rst` = 0, `ready` = 0.
  - If `locked_s` = 0: go to WAIT_LOCK, counter = 0. No retry count; the timeout window restarts.
  - Else if counter = STABLE_CYCLES-1: go to RUN.
  - Else the counter increments.
- RUN:
  - `pll_rst` = 0, `ready` = 1.
  - If `locked_s` = 0: go to RESET, counter = 0, `loss_cnt` += 1 (saturating).
  - `ready` goes to 0 on the same clock edge that leaves RUN.
  - Worst-case `ready` deassert: 3 refclk cycles after `pll_locked` falls (2 sync + 1 register).
- Entry timing: `ready` rises on the edge that enters RUN, i.e. STABLE_CYCLES cycles after entering STABLE.
- Simultaneous events:
  - `relock_req` with `locked_s` falling in RUN: RESET is taken and `loss_cnt` is not incremented.
  - Timeout and `locked_s` rising on the same cycle: lock wins, go to STABLE.
- Saturation: counters at 255 stay at 255; they never wrap.
- Counter compares are exact equality. The counter never exceeds its active limit.
- rst_n asserted mid-sequence: immediate return to the reset values, independent of refclk.
- rst_n deassertion is assumed to meet recovery timing through an external reset synchronizer.

Test Plan:
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
1. Release rst_n with `pll_locked` tied 1 -> `pll_rst` high exactly 4 cycles. `ready` rises 4 + 2 + 8 (±1 for the WAIT_LOCK sample) cycles later, identical across runs. `retry_cnt` = 0.
2. `pll_locked` held 0 for 70 cycles, then 1 -> `timeout_pulse` fires 3 times, each followed by a 4-cycle `pll_rst`. `retry_cnt` = 3, then `ready` = 1.
3. In STABLE, drop `pll_locked` for 1 cycle at stable count 5 -> back to WAIT_LOCK, no `pll_rst`. `ready` is delayed by a full 8-cycle window after relock.
4. In RUN, drop `pll_locked` -> `ready` = 0 within 3 cycles, `pll_rst` pulses 4 cycles, `loss_cnt` = 1. Relock returns `ready` = 1.
5. Assert `relock_req` for 1 cycle in RUN -> `ready` = 0 next edge, 4-cycle `pll_rst`. `loss_cnt` and `retry_cnt` unchanged.
6. Force 300 timeouts -> `retry_cnt` reads 255 with no wrap. Assert rst_n mid-WAIT_LOCK -> `pll_rst` = 1 and `ready` = 0 asynchronously, both counters = 0.
